// File: rtl/demorgan_sweep_pkg.sv
// rtl/demorgan_sweep_pkg.sv - shared state encoding and sizing helper for the De Morgan sweep sequencer
//
// Purpose: state encoding shared by the sequencer and anything that inspects it,
//          plus the vector-count helper used to size the sweep.
// Contents: state_t (ST_IDLE, ST_DRIVE, ST_CHECK, ST_DONE), vec_count().
package demorgan_sweep_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_CHECK = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Number of (a, b) operand pairs for a given operand width.
    function automatic int vec_count(input int width);
        return 1 << (2 * width);
    endfunction

endpackage

// File: rtl/demorgan_golden_cmp.sv
// rtl/demorgan_golden_cmp.sv - combinational golden compare for one De Morgan result vector
//
// Purpose: flags a vector whose results disagree with each other or with the
//          golden NOR/NAND of the driven operands.
// Ports:
//   a_i, b_i      operands currently driven to the datapath
//   cos_i, poc_i  datapath ~(a|b) and ~a&~b results
//   cop_i, soc_i  datapath ~(a&b) and ~a|~b results
//   fail_o        1 when any of the four checks disagrees
module demorgan_golden_cmp #(
    parameter int WIDTH = 2
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic [WIDTH-1:0] cos_i,
    input  logic [WIDTH-1:0] poc_i,
    input  logic [WIDTH-1:0] cop_i,
    input  logic [WIDTH-1:0] soc_i,
    output logic             fail_o
);

    logic [WIDTH-1:0] nor_gold;
    logic [WIDTH-1:0] nand_gold;

    assign nor_gold  = ~(a_i | b_i);
    assign nand_gold = ~(a_i & b_i);

    // Pairwise checks catch a broken form of either law; golden checks catch
    // a datapath where both forms are wrong in the same way.
    assign fail_o = (cos_i != poc_i)    ||
                    (cop_i != soc_i)    ||
                    (cos_i != nor_gold) ||
                    (cop_i != nand_gold);

endmodule

// File: rtl/demorgan_sweep_ctrl.sv
// rtl/demorgan_sweep_ctrl.sv - self-test sequencer sweeping every operand pair through the De Morgan datapath
//
// Purpose: on start, drives every (a, b) pair with b as the major index, holds
//          each for HOLD_CYCLES, checks the returned results, counts failing
//          vectors, captures the first failing pair and pulses done.
// Ports:
//   clk, rst        clock (rising edge) and asynchronous active-high reset
//   start, abort    begin a sweep (IDLE only) / cancel a sweep without done
//   cos_i..soc_i    datapath result buses
//   a_o, b_o        registered operands to the datapath
//   busy            high in DRIVE and CHECK
//   done            one-cycle completion pulse
//   pass            1 when the last completed sweep had no failures
//   err_cnt         failing-vector count of the last sweep
//   fail_a, fail_b  operands of the first failing vector
module demorgan_sweep_ctrl
    import demorgan_sweep_pkg::*;
#(
    parameter int WIDTH       = 2,
    parameter int HOLD_CYCLES = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               abort,
    input  logic [WIDTH-1:0]   cos_i,
    input  logic [WIDTH-1:0]   poc_i,
    input  logic [WIDTH-1:0]   cop_i,
    input  logic [WIDTH-1:0]   soc_i,
    output logic [WIDTH-1:0]   a_o,
    output logic [WIDTH-1:0]   b_o,
    output logic               busy,
    output logic               done,
    output logic               pass,
    output logic [2*WIDTH:0]   err_cnt,
    output logic [WIDTH-1:0]   fail_a,
    output logic [WIDTH-1:0]   fail_b
);

    localparam int IW     = 2 * WIDTH;
    localparam int EW     = 2 * WIDTH + 1;
    localparam int N_VEC  = vec_count(WIDTH);
    localparam int HW     = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

    localparam logic [IW-1:0] IDX_LAST  = IW'(N_VEC - 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);

    state_t            state_q;
    logic [IW-1:0]     idx_q;
    logic [HW-1:0]     hold_q;
    logic              busy_q;
    logic              done_q;
    logic              pass_q;
    logic [EW-1:0]     err_cnt_q;
    logic [WIDTH-1:0]  fail_a_q;
    logic [WIDTH-1:0]  fail_b_q;

    logic              vec_fail;

    // Operands come straight off the index register, so they are registered.
    assign a_o = idx_q[WIDTH-1:0];
    assign b_o = idx_q[IW-1:WIDTH];

    demorgan_golden_cmp #(
        .WIDTH (WIDTH)
    ) u_cmp (
        .a_i    (a_o),
        .b_i    (b_o),
        .cos_i  (cos_i),
        .poc_i  (poc_i),
        .cop_i  (cop_i),
        .soc_i  (soc_i),
        .fail_o (vec_fail)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            idx_q     <= '0;
            hold_q    <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            pass_q    <= 1'b0;
            err_cnt_q <= '0;
            fail_a_q  <= '0;
            fail_b_q  <= '0;
        end else begin
            done_q <= 1'b0;
            if (state_q != ST_IDLE && abort) begin
                // Partial results stay visible; pass was cleared at start.
                state_q <= ST_IDLE;
                busy_q  <= 1'b0;
                hold_q  <= '0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (start && !abort) begin
                            state_q   <= ST_DRIVE;
                            busy_q    <= 1'b1;
                            idx_q     <= '0;
                            hold_q    <= '0;
                            err_cnt_q <= '0;
                            fail_a_q  <= '0;
                            fail_b_q  <= '0;
                            pass_q    <= 1'b0;
                        end
                    end
                    ST_DRIVE: begin
                        if (hold_q == HOLD_LAST) begin
                            hold_q  <= '0;
                            state_q <= ST_CHECK;
                        end else begin
                            hold_q <= hold_q + HW'(1);
                        end
                    end
                    ST_CHECK: begin
                        if (vec_fail) begin
                            err_cnt_q <= err_cnt_q + EW'(1);
                            if (err_cnt_q == '0) begin
                                fail_a_q <= a_o;
                                fail_b_q <= b_o;
                            end
                        end
                        if (idx_q == IDX_LAST) begin
                            // idx is left at the last vector rather than wrapping.
                            state_q <= ST_DONE;
                            busy_q  <= 1'b0;
                        end else begin
                            idx_q   <= idx_q + IW'(1);
                            state_q <= ST_DRIVE;
                        end
                    end
                    ST_DONE: begin
                        done_q  <= 1'b1;
                        pass_q  <= (err_cnt_q == '0);
                        state_q <= ST_IDLE;
                    end
                    default: begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign pass    = pass_q;
    assign err_cnt = err_cnt_q;
    assign fail_a  = fail_a_q;
    assign fail_b  = fail_b_q;

endmodule

// File: tb/tb_demorgan_sweep_ctrl.sv
// tb/tb_demorgan_sweep_ctrl.sv - directed-vector bench for the De Morgan sweep sequencer
module tb_demorgan_sweep_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic [1:0] cos_m, poc_m, cop_m, soc_m;
    logic [1:0] a_o, b_o;
    logic       busy, done, pass;
    logic [4:0] err_cnt;
    logic [1:0] fail_a, fail_b;

    // 0: correct datapath, 1: poc[0] stuck at 0, 2: soc inverted at a=3,b=3
    int mode = 0;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    demorgan_sweep_ctrl #(.WIDTH(2), .HOLD_CYCLES(1)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .abort   (abort),
        .cos_i   (cos_m),
        .poc_i   (poc_m),
        .cop_i   (cop_m),
        .soc_i   (soc_m),
        .a_o     (a_o),
        .b_o     (b_o),
        .busy    (busy),
        .done    (done),
        .pass    (pass),
        .err_cnt (err_cnt),
        .fail_a  (fail_a),
        .fail_b  (fail_b)
    );

    // Behavioural datapath with optional planted faults.
    always_comb begin
        cos_m = ~(a_o | b_o);
        poc_m = ~a_o & ~b_o;
        cop_m = ~(a_o & b_o);
        soc_m = ~a_o | ~b_o;
        if (mode == 1) poc_m[0] = 1'b0;
        if (mode == 2 && a_o == 2'd3 && b_o == 2'd3) soc_m = ~(~a_o | ~b_o);
    end

    // Start is sampled on the following edge; returns #1 after that edge (edge 0).
    task automatic pulse_start();
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Runs ncyc edges after edge 0, reporting the first edge showing done and the pulse count.
    task automatic run_edges(input int ncyc, output int done_at, output int n_done);
        done_at = -1;
        n_done  = 0;
        for (int k = 1; k <= ncyc; k++) begin
            @(posedge clk); #1;
            if (done === 1'b1) begin
                n_done++;
                if (done_at < 0) done_at = k;
            end
        end
    endtask

    task automatic test_reset();
        #2;
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %0b want 0", busy); end
        n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done got %0b want 0", done); end
        n_vec++; if (pass !== 1'b0) begin n_err++; $display("FAIL reset_pass got %0b want 0", pass); end
        n_vec++; if (err_cnt !== 5'd0) begin n_err++; $display("FAIL reset_err_cnt got %0d want 0", err_cnt); end
        n_vec++; if ({a_o, b_o, fail_a, fail_b} !== 8'h00) begin n_err++; $display("FAIL reset_ops got %h want 00", {a_o, b_o, fail_a, fail_b}); end
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL idle_busy got %0b want 0", busy); end
    endtask

    task automatic test_clean_sweep();
        int done_at, n_done;
        mode = 0;
        pulse_start();
        done_at = -1;
        n_done  = 0;
        for (int k = 0; k <= 40; k++) begin
            if (k > 0) begin @(posedge clk); #1; end
            if (k <= 30 && (k % 2) == 0) begin
                n_vec++; if (a_o !== 2'((k / 2) % 4) || b_o !== 2'((k / 2) / 4) || busy !== 1'b1) begin
                    n_err++; $display("FAIL clean_vec%0d got a=%0d b=%0d busy=%0b want a=%0d b=%0d busy=1",
                                      k / 2, a_o, b_o, busy, (k / 2) % 4, (k / 2) / 4);
                end
            end
            if (done === 1'b1) begin
                n_done++;
                if (done_at < 0) done_at = k;
                n_vec++; if (pass !== 1'b1) begin n_err++; $display("FAIL clean_pass_at_done got %0b want 1", pass); end
            end
        end
        n_vec++; if (done_at != 33) begin n_err++; $display("FAIL clean_done_cycle got %0d want 33", done_at); end
        n_vec++; if (n_done != 1) begin n_err++; $display("FAIL clean_done_pulses got %0d want 1", n_done); end
        n_vec++; if (pass !== 1'b1 || err_cnt !== 5'd0) begin n_err++; $display("FAIL clean_result got pass=%0b err=%0d want pass=1 err=0", pass, err_cnt); end
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL clean_busy_after got %0b want 0", busy); end
    endtask

    task automatic test_stuck_poc();
        int done_at, n_done;
        mode = 1;
        pulse_start();
        run_edges(40, done_at, n_done);
        n_vec++; if (done_at != 33 || n_done != 1) begin n_err++; $display("FAIL stuck_done got cycle=%0d pulses=%0d want 33/1", done_at, n_done); end
        n_vec++; if (err_cnt !== 5'd4) begin n_err++; $display("FAIL stuck_err_cnt got %0d want 4", err_cnt); end
        n_vec++; if (pass !== 1'b0) begin n_err++; $display("FAIL stuck_pass got %0b want 0", pass); end
        n_vec++; if (fail_a !== 2'd0 || fail_b !== 2'd0) begin n_err++; $display("FAIL stuck_first got a=%0d b=%0d want 0/0", fail_a, fail_b); end
    endtask

    task automatic test_soc_corner();
        int done_at, n_done;
        mode = 2;
        pulse_start();
        run_edges(40, done_at, n_done);
        n_vec++; if (done_at != 33) begin n_err++; $display("FAIL corner_done got %0d want 33", done_at); end
        n_vec++; if (err_cnt !== 5'd1) begin n_err++; $display("FAIL corner_err_cnt got %0d want 1", err_cnt); end
        n_vec++; if (fail_a !== 2'd3 || fail_b !== 2'd3) begin n_err++; $display("FAIL corner_first got a=%0d b=%0d want 3/3", fail_a, fail_b); end
        n_vec++; if (pass !== 1'b0) begin n_err++; $display("FAIL corner_pass got %0b want 0", pass); end
    endtask

    task automatic test_abort();
        int done_at, n_done;
        mode = 1;
        pulse_start();
        for (int k = 1; k <= 9; k++) begin @(posedge clk); #1; end
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL abort_busy got %0b want 0", busy); end
        n_vec++; if (err_cnt !== 5'd2) begin n_err++; $display("FAIL abort_partial_err got %0d want 2", err_cnt); end
        n_vec++; if (pass !== 1'b0 || fail_a !== 2'd0 || fail_b !== 2'd0) begin n_err++; $display("FAIL abort_partial got pass=%0b a=%0d b=%0d want 0/0/0", pass, fail_a, fail_b); end
        run_edges(40, done_at, n_done);
        n_vec++; if (n_done != 0) begin n_err++; $display("FAIL abort_no_done got %0d pulses want 0", n_done); end
        // abort together with start in IDLE: stays idle
        @(posedge clk); #1;
        start = 1'b1; abort = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; abort = 1'b0;
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL abort_wins_busy got %0b want 0", busy); end
        mode = 0;
        pulse_start();
        n_vec++; if (err_cnt !== 5'd0 || busy !== 1'b1) begin n_err++; $display("FAIL restart_clear got err=%0d busy=%0b want 0/1", err_cnt, busy); end
        run_edges(40, done_at, n_done);
        n_vec++; if (done_at != 33 || pass !== 1'b1 || err_cnt !== 5'd0) begin
            n_err++; $display("FAIL restart_sweep got done=%0d pass=%0b err=%0d want 33/1/0", done_at, pass, err_cnt);
        end
    endtask

    task automatic test_back_to_back();
        int done_at, n_done;
        mode = 0;
        pulse_start();
        done_at = -1;
        n_done  = 0;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk); #1;
            start = (k == 4);
            if (done === 1'b1) begin
                n_done++;
                if (done_at < 0) done_at = k;
            end
        end
        start = 1'b0;
        n_vec++; if (done_at != 33) begin n_err++; $display("FAIL b2b_done_cycle got %0d want 33", done_at); end
        n_vec++; if (n_done != 1) begin n_err++; $display("FAIL b2b_done_pulses got %0d want 1", n_done); end
    endtask

    task automatic test_async_reset();
        int done_at, n_done;
        mode = 1;
        pulse_start();
        for (int k = 1; k <= 10; k++) begin @(posedge clk); #1; end
        n_vec++; if (busy !== 1'b1 || err_cnt !== 5'd2 || a_o !== 2'd1 || b_o !== 2'd1) begin
            n_err++; $display("FAIL pre_rst got busy=%0b err=%0d a=%0d b=%0d want 1/2/1/1", busy, err_cnt, a_o, b_o);
        end
        #2;
        rst = 1'b1;
        #1;
        n_vec++; if ({busy, done, pass} !== 3'b000 || err_cnt !== 5'd0 || {a_o, b_o, fail_a, fail_b} !== 8'h00) begin
            n_err++; $display("FAIL async_rst got busy=%0b done=%0b pass=%0b err=%0d ops=%h want all 0",
                              busy, done, pass, err_cnt, {a_o, b_o, fail_a, fail_b});
        end
        @(posedge clk); #3;
        rst = 1'b0;
        mode = 0;
        pulse_start();
        run_edges(40, done_at, n_done);
        n_vec++; if (done_at != 33 || n_done != 1 || pass !== 1'b1 || err_cnt !== 5'd0) begin
            n_err++; $display("FAIL post_rst_sweep got done=%0d pulses=%0d pass=%0b err=%0d want 33/1/1/0",
                              done_at, n_done, pass, err_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_clean_sweep();
        test_stuck_poc();
        test_soc_corner();
        test_abort();
        test_back_to_back();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/demorgan_sweep_ctrl.md
Name: demorgan_sweep_ctrl

Overview:
Self-test sequencer for the 2-bit De Morgan dataflow datapath (NOR/NAND outputs cos, poc, cop, soc).
- On start, sweeps every (a, b) operand pair into the datapath.
- Checks each result pair against the other and against a golden model.
- Counts mismatches, captures the first failing vector, and signals completion with a done pulse.
- Sits beside the datapath in lab/board builds.
- Operands go out through a_o/b_o; datapath results come back in through the four result inputs.

Parameters:
- WIDTH, 2, operand width of the datapath (a, b, and each result bus).
- HOLD_CYCLES, 1, settle cycles each vector is held before sampling (≥1).

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-high reset
- start  input  1  one-cycle request to begin a sweep; ignored unless state is IDLE
- abort  input  1  synchronous cancel; returns to IDLE without a done pulse
- cos_i  input  WIDTH  datapath ~(a|b)
- poc_i  input  WIDTH  datapath ~a&~b
- cop_i  input  WIDTH  datapath ~(a&b)
- soc_i  input  WIDTH  datapath ~a|~b
- a_o  output  WIDTH  operand a driven to datapath
- b_o  output  WIDTH  operand b driven to datapath
- busy  output  1  high in DRIVE and CHECK
- done  output  1  one-cycle pulse when a sweep completes
- pass  output  1  valid from done onward: 1 when err_cnt==0
- err_cnt  output  2*WIDTH+1  number of failing vectors in the last sweep
- fail_a  output  WIDTH  a of the first failing vector
- fail_b  output  WIDTH  b of the first failing vector

Behaviour:
- Reset values: all outputs 0, state IDLE, idx=0, hold counter 0.
- Vector index idx is 2*WIDTH bits. a_o = idx[WIDTH-1:0], b_o = idx[2*WIDTH-1:WIDTH]. Both are registered.
- Vector count N = 2^(2*WIDTH); N = 16 at the default width.
- IDLE:
  - start=1 → DRIVE next cycle.
  - Same edge clears idx, err_cnt, fail_a, fail_b and pass.
- DRIVE:
  - Holds a_o/b_o for HOLD_CYCLES cycles.
  - Then → CHECK.
- CHECK (one cycle):
  - Vector fails if any of: cos_i!=poc_i; cop_i!=soc_i; cos_i!=~(a_o|b_o); cop_i!=~(a_o&b_o).
  - On fail: err_cnt increments.
  - If this is the first failure (err_cnt was 0), fail_a and fail_b capture a_o and b_o.
  - If idx==N-1 → DONE. Otherwise idx increments → DRIVE.
- DONE (one cycle):
  - done=1; pass = (err_cnt==0).
  - → IDLE.
  - pass, err_cnt, fail_a and fail_b then hold until the next start.
- Sweep latency from the start edge to the done pulse: N*(HOLD_CYCLES+1) cycles, plus the DONE cycle.
  - At defaults: done asserted on cycle 33 after the start edge.
- Counters:
  - err_cnt cannot overflow, since its maximum value N fits in 2*WIDTH+1 bits.
  - idx does not wrap; DONE is taken at N-1.
- start while busy or in DONE: ignored, with no restart.
- abort:
  - In any non-IDLE state → IDLE next cycle; busy=0, no done pulse.
  - err_cnt and fail_* keep their partial values; pass stays 0.
  - abort and start together in IDLE: abort wins and the block stays IDLE.
- Asynchronous rst mid-sweep: immediate return to reset values, including done.

Decomposition:
- Shared package holds:
  - state encoding constants ST_IDLE, ST_DRIVE, ST_CHECK, ST_DONE (2 bits);
  - function vec_count(WIDTH) = 1<<(2*WIDTH).
- One sub-module: demorgan_golden_cmp.
  - Purely combinational.
  - Inputs: a, b, and the four result buses.
  - Output: fail flag.
  - Keeps the compare logic separately testable; the FSM and counters live in the top.

Test Plan:
- Correct datapath model, defaults, start pulse → done on cycle 33; pass=1, err_cnt=0; a_o/b_o step through 0..3 × 0..3 with b as the major index.
- Model with poc_i[0] stuck at 0 → fails wherever a[0]=0 and b[0]=0, which is 4 vectors; err_cnt=4, pass=0, fail_a=0, fail_b=0 (first failure is idx 0).
- Model with soc_i = ~soc_true only when a=3 and b=3 → err_cnt=1, fail_a=3, fail_b=3.
- abort asserted in cycle 10 of a sweep → IDLE next cycle, no done pulse; then start → full sweep with err_cnt cleared at start.
- start pulsed again at cycle 5 while busy → ignored; done still on cycle 33, one done pulse only.
- rst raised mid-sweep, asynchronously between clock edges → all outputs 0 immediately; a following start gives a normal sweep.
